// File: rtl/mem_pkg.sv
// Shared memory-side definitions: opcode encoding used by mem_ctrl and its
// requesters, plus the arbiter FSM state encoding.
package mem_pkg;

   // Opcode on the controller and requester buses. 2'b10 is unused and is
   // never forwarded to the controller.
   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b11
   } mem_op_e;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      ST_INIT = 2'b00,
      ST_ARB  = 2'b01,
      ST_BUSY = 2'b10
   } arb_state_e;

   // True for the opcodes that start a controller transaction.
   function automatic logic op_is_xfer(input logic [1:0] op);
      return (op == OP_READ) || (op == OP_WRITE);
   endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_picker.sv
// Combinational round-robin selector: returns a one-hot pick of the first
// set request bit found after the last granted index, wrapping around.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] gnt_o
);

   logic found;
   int   idx;

   // Scan last+1 .. last+NUM_REQ (mod NUM_REQ); the first hit wins.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last_i) + i) % NUM_REQ;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one mem_ctrl between NUM_REQ requesters.
// One whole cache-line transaction is granted at a time; op, address and
// write words are muxed from the owner, read words/pops/done go back to it.
//
// Handshake: a requester holds req_valid/req_op/req_addr stable from the
// cycle it raises them until the cycle req_done pulses, and updates them at
// the following edge. req_wr_pop means the current req_wdata word is taken
// this cycle and the requester presents the next word from the next cycle.
// The controller side is driven only while the FSM is BUSY; ARB always
// presents OP_IDLE for at least one cycle between transactions.
module mem_req_arbiter
   import mem_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int WORD_SIZE     = 32,
   parameter int CL_SIZE_WIDTH = 512,
   parameter int ADDR_BITCOUNT = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   // requester side
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [2*NUM_REQ-1:0]              req_op,
   input  logic [ADDR_BITCOUNT*NUM_REQ-1:0]  req_addr,
   input  logic [WORD_SIZE*NUM_REQ-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]                req_grant,
   output logic [NUM_REQ-1:0]                req_wr_pop,
   output logic [NUM_REQ-1:0]                req_rd_valid,
   output logic [WORD_SIZE-1:0]              req_rdata,
   output logic [NUM_REQ-1:0]                req_done,
   // memory-controller side
   input  logic                              mc_ready,
   input  logic                              mc_tx_done,
   input  logic                              mc_rd_valid,
   input  logic [WORD_SIZE-1:0]              mc_rdata,
   output logic [1:0]                        mc_op,
   output logic [ADDR_BITCOUNT-1:0]          mc_addr,
   output logic [WORD_SIZE-1:0]              mc_wdata,
   // debug: current FSM state (arb_state_e encoding)
   output logic [1:0]                        dbg_state
);

   localparam int FILL_COUNT = CL_SIZE_WIDTH / WORD_SIZE;
   localparam int FILL_BITS  = $clog2(FILL_COUNT) + 1;
   localparam int PTR_W      = $clog2(NUM_REQ);

   // Phase value at which write pops are finished and the counter holds.
   localparam logic [FILL_BITS-1:0] PHASE_SAT = FILL_BITS'(FILL_COUNT + 1);
   localparam logic [FILL_BITS-1:0] PHASE_MAX = FILL_BITS'(FILL_COUNT);

   arb_state_e             state_q;
   logic [NUM_REQ-1:0]     grant_q;
   mem_op_e                op_q;
   logic [FILL_BITS-1:0]   phase_q;
   logic [PTR_W-1:0]       last_q;

   logic [NUM_REQ-1:0]     eligible;
   logic [NUM_REQ-1:0]     pick;
   logic [1:0]             pick_op;
   logic [PTR_W-1:0]       last_d;
   logic                   busy;

   // A request is eligible only with valid set and a read/write opcode.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] && op_is_xfer(req_op[2*i +: 2]);
      end
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .req_i   (eligible),
      .last_i  (last_q),
      .gnt_o   (pick)
   );

   // Opcode of the picked requester and index of the current owner.
   always_comb begin
      pick_op = 2'b00;
      last_d  = last_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_op = req_op[2*i +: 2];
         if (grant_q[i]) last_d = PTR_W'(i);
      end
   end

   // Arbiter FSM: INIT waits for the controller, ARB picks, BUSY owns a line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         grant_q <= '0;
         op_q    <= OP_IDLE;
         phase_q <= '0;
         last_q  <= PTR_W'(NUM_REQ - 1);
      end else begin
         case (state_q)
            ST_INIT: begin
               if (mc_ready) state_q <= ST_ARB;
            end
            ST_ARB: begin
               if (|eligible) begin
                  grant_q <= pick;
                  op_q    <= mem_op_e'(pick_op);
                  phase_q <= '0;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (phase_q != PHASE_SAT) phase_q <= phase_q + 1'b1;
               if (mc_tx_done) begin
                  last_q  <= last_d;
                  grant_q <= '0;
                  op_q    <= OP_IDLE;
                  state_q <= ST_ARB;
               end
            end
            default: begin
               state_q <= ST_INIT;
               grant_q <= '0;
               op_q    <= OP_IDLE;
            end
         endcase
      end
   end

   assign busy      = (state_q == ST_BUSY);
   assign req_grant = grant_q;
   assign dbg_state = state_q;

   // Route the owner's request to the controller and the controller's
   // responses back to the owner; everything is zero outside BUSY.
   always_comb begin
      mc_op        = OP_IDLE;
      mc_addr      = '0;
      mc_wdata     = '0;
      req_rdata    = '0;
      req_rd_valid = '0;
      req_done     = '0;
      req_wr_pop   = '0;
      if (busy) begin
         mc_op        = op_q;
         req_rdata    = mc_rdata;
         req_rd_valid = grant_q & {NUM_REQ{mc_rd_valid}};
         req_done     = grant_q & {NUM_REQ{mc_tx_done}};
         if (op_q == OP_WRITE && phase_q != '0 && phase_q <= PHASE_MAX) begin
            req_wr_pop = grant_q;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
               mc_addr  = req_addr[ADDR_BITCOUNT*i +: ADDR_BITCOUNT];
               mc_wdata = req_wdata[WORD_SIZE*i +: WORD_SIZE];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: the driver issues per-cycle stimulus and
// pushes the hand-derived response for every active cycle; a monitor compares
// the DUT outputs against the queue whenever any output is active.
module tb_mem_req_arbiter;
   import mem_pkg::*;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int A  = 64;
   localparam int FC = 16;
   localparam int RW = 4*N + 2 + A + 2*W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [N-1:0]      req_valid;
   logic [2*N-1:0]    req_op;
   logic [A*N-1:0]    req_addr;
   logic [W*N-1:0]    req_wdata;
   logic [N-1:0]      req_grant, req_wr_pop, req_rd_valid, req_done;
   logic [W-1:0]      req_rdata;
   logic              mc_ready, mc_tx_done, mc_rd_valid;
   logic [W-1:0]      mc_rdata;
   logic [1:0]        mc_op;
   logic [A-1:0]      mc_addr;
   logic [W-1:0]      mc_wdata;
   logic [1:0]        dbg_state;

   mem_req_arbiter #(
      .NUM_REQ       (N),
      .WORD_SIZE     (W),
      .CL_SIZE_WIDTH (512),
      .ADDR_BITCOUNT (A)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_grant    (req_grant),
      .req_wr_pop   (req_wr_pop),
      .req_rd_valid (req_rd_valid),
      .req_rdata    (req_rdata),
      .req_done     (req_done),
      .mc_ready     (mc_ready),
      .mc_tx_done   (mc_tx_done),
      .mc_rd_valid  (mc_rd_valid),
      .mc_rdata     (mc_rdata),
      .mc_op        (mc_op),
      .mc_addr      (mc_addr),
      .mc_wdata     (mc_wdata),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [RW-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;
   int ev_n  = 0;

   function automatic logic [W-1:0] wbg(input int i);
      return 32'hB0B0_0000 + W'(i);
   endfunction

   function automatic logic [W-1:0] wword(input int k);
      return 32'hA500_0000 + W'(k);
   endfunction

   function automatic logic [W-1:0] rword(input int k);
      return 32'h5A00_0000 + W'(k * 32'h111);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [1:0] op,
                          input logic [A-1:0] ad, input logic [W-1:0] wd);
      req_valid[i]       = v;
      req_op[2*i +: 2]   = op;
      req_addr[A*i +: A] = ad;
      req_wdata[W*i +: W] = wd;
   endtask

   task automatic set_bg();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, OP_IDLE, 64'h100 * (i + 1), wbg(i));
   endtask

   task automatic push_exp(input logic [N-1:0] g, input logic [N-1:0] pop,
                           input logic [N-1:0] rdv, input logic [N-1:0] dn,
                           input logic [1:0] op, input logic [A-1:0] ad,
                           input logic [W-1:0] wd, input logic [W-1:0] rd);
      exp_q.push_back({g, pop, rdv, dn, op, ad, wd, rd});
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_grant"}, 64'(req_grant), 64'h0);
      chk({nm, "_mc_op"}, 64'(mc_op), 64'h0);
      chk({nm, "_mc_addr"}, mc_addr, 64'h0);
      chk({nm, "_mc_wdata"}, 64'(mc_wdata), 64'h0);
      chk({nm, "_rdata"}, 64'(req_rdata), 64'h0);
      chk({nm, "_flags"}, 64'({req_wr_pop, req_rd_valid, req_done}), 64'h0);
      chk({nm, "_state"}, 64'(dbg_state), 64'(ST_INIT));
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [RW-1:0] got;
      logic [RW-1:0] e;
      forever begin
         @(negedge clk);
         if ((|req_grant) || (|req_wr_pop) || (|req_rd_valid) || (|req_done) || (mc_op != 2'b00)) begin
            got = {req_grant, req_wr_pop, req_rd_valid, req_done, mc_op, mc_addr, mc_wdata, req_rdata};
            total++;
            ev_n++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected ev=%0d got=%h", ev_n, got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  bad++;
                  $display("FAIL sb_event ev=%0d got=%h exp=%h", ev_n, got, e);
               end
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int fair_seq[5];
      fair_seq = '{0, 1, 2, 3, 0};

      rst = 1'b1; mc_ready = 1'b0; mc_tx_done = 1'b0; mc_rd_valid = 1'b0; mc_rdata = '0;
      req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0;
      set_bg();
      repeat (3) tick();
      rst = 1'b0;
      #1 chk_all_zero("reset");

      // Startup hold: request pending but controller not ready.
      set_req(0, 1'b1, OP_READ, 64'h40, wbg(0));
      for (int c = 0; c < 10; c++) begin
         tick();
         #1;
         chk("hold_grant", 64'(req_grant), 64'h0);
         chk("hold_op", 64'(mc_op), 64'h0);
      end
      tick(); mc_ready = 1'b1;
      tick(); #1 chk("start_arb_state", 64'(dbg_state), 64'(ST_ARB));
      tick(); mc_tx_done = 1'b1;
      push_exp(4'b0001, 4'b0, 4'b0, 4'b0001, OP_READ, 64'h40, wbg(0), 32'h0);
      #1 chk("start_grant", 64'(req_grant), 64'h1);
      tick(); mc_tx_done = 1'b0; set_req(0, 1'b0, OP_IDLE, 64'h100, wbg(0));

      // Single write from requester 2.
      tick(); set_req(2, 1'b1, OP_WRITE, 64'h1000, wword(0));
      tick(); push_exp(4'b0100, 4'b0, 4'b0, 4'b0, OP_WRITE, 64'h1000, wword(0), 32'h0);
      for (int k = 1; k <= FC; k++) begin
         tick();
         req_wdata[W*2 +: W] = wword(k - 1);
         push_exp(4'b0100, 4'b0100, 4'b0, 4'b0, OP_WRITE, 64'h1000, wword(k - 1), 32'h0);
      end
      tick(); mc_tx_done = 1'b1;
      push_exp(4'b0100, 4'b0, 4'b0, 4'b0100, OP_WRITE, 64'h1000, wword(15), 32'h0);
      tick(); mc_tx_done = 1'b0; set_req(2, 1'b0, OP_IDLE, 64'h300, wbg(2));

      // Single read from requester 1.
      tick(); set_req(1, 1'b1, OP_READ, 64'h2000, wbg(1));
      tick(); push_exp(4'b0010, 4'b0, 4'b0, 4'b0, OP_READ, 64'h2000, wbg(1), 32'h0);
      for (int k = 0; k < FC; k++) begin
         tick();
         mc_rd_valid = 1'b1;
         mc_rdata    = rword(k);
         mc_tx_done  = (k == FC - 1);
         push_exp(4'b0010, 4'b0, 4'b0010, (k == FC - 1) ? 4'b0010 : 4'b0000,
                  OP_READ, 64'h2000, wbg(1), rword(k));
      end
      tick(); mc_rd_valid = 1'b0; mc_rdata = '0; mc_tx_done = 1'b0;
      set_req(1, 1'b0, OP_IDLE, 64'h200, wbg(1));

      // Fairness after a fresh reset: all four requesters stay valid.
      tick(); rst = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, OP_READ, 64'h3000 + 64'h40 * i, wbg(i));
      tick(); rst = 1'b0;
      #1 chk("fair_init_state", 64'(dbg_state), 64'(ST_INIT));
      tick(); #1 chk("fair_arb_state", 64'(dbg_state), 64'(ST_ARB));
      for (int t = 0; t < 5; t++) begin
         tick();
         push_exp(4'(1 << fair_seq[t]), 4'b0, 4'b0, 4'b0, OP_READ,
                  64'h3000 + 64'h40 * fair_seq[t], wbg(fair_seq[t]), 32'h0);
         tick(); mc_tx_done = 1'b1;
         push_exp(4'(1 << fair_seq[t]), 4'b0, 4'b0, 4'(1 << fair_seq[t]), OP_READ,
                  64'h3000 + 64'h40 * fair_seq[t], wbg(fair_seq[t]), 32'h0);
         tick(); mc_tx_done = 1'b0;
      end
      set_bg();

      // Illegal op on requester 0, op change on requester 3 while busy.
      tick();
      set_req(0, 1'b1, 2'b10, 64'h50, wbg(0));
      set_req(3, 1'b1, OP_READ, 64'h4000, wbg(3));
      tick(); push_exp(4'b1000, 4'b0, 4'b0, 4'b0, OP_READ, 64'h4000, wbg(3), 32'h0);
      tick(); req_op[7:6] = OP_WRITE;
      push_exp(4'b1000, 4'b0, 4'b0, 4'b0, OP_READ, 64'h4000, wbg(3), 32'h0);
      tick(); req_op[7:6] = OP_IDLE;
      push_exp(4'b1000, 4'b0, 4'b0, 4'b0, OP_READ, 64'h4000, wbg(3), 32'h0);
      tick(); mc_tx_done = 1'b1;
      push_exp(4'b1000, 4'b0, 4'b0, 4'b1000, OP_READ, 64'h4000, wbg(3), 32'h0);
      tick(); mc_tx_done = 1'b0; set_req(3, 1'b0, OP_IDLE, 64'h400, wbg(3));
      for (int c = 0; c < 6; c++) begin
         tick();
         #1 chk("illegal_no_grant", 64'(req_grant), 64'h0);
      end
      set_req(0, 1'b0, OP_IDLE, 64'h100, wbg(0));

      // Reset in the middle of a write, at the fifth pop.
      tick(); set_req(2, 1'b1, OP_WRITE, 64'h5000, wword(0));
      tick(); push_exp(4'b0100, 4'b0, 4'b0, 4'b0, OP_WRITE, 64'h5000, wword(0), 32'h0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         req_wdata[W*2 +: W] = wword(k - 1);
         push_exp(4'b0100, 4'b0100, 4'b0, 4'b0, OP_WRITE, 64'h5000, wword(k - 1), 32'h0);
         if (k == 5) begin
            rst      = 1'b1;
            mc_ready = 1'b0;
         end
      end
      tick(); rst = 1'b0; req_wdata[W*2 +: W] = wword(0);
      #1 chk_all_zero("midrst");
      for (int c = 0; c < 5; c++) begin
         tick();
         #1 chk("midrst_hold_grant", 64'(req_grant), 64'h0);
      end
      tick(); mc_ready = 1'b1;
      tick(); #1 chk("midrst_arb_state", 64'(dbg_state), 64'(ST_ARB));
      tick(); push_exp(4'b0100, 4'b0, 4'b0, 4'b0, OP_WRITE, 64'h5000, wword(0), 32'h0);
      tick(); mc_tx_done = 1'b1;
      push_exp(4'b0100, 4'b0100, 4'b0, 4'b0100, OP_WRITE, 64'h5000, wword(0), 32'h0);
      tick(); mc_tx_done = 1'b0; set_req(2, 1'b0, OP_IDLE, 64'h300, wbg(2));

      // Drain: every expected event must have been observed.
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
      repeat (3) tick();
      chk("sb_drain_left", 64'(exp_q.size()), 64'h0);

      // ---------------- report ----------------
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
